microwave_timer: RTL and testbench



---
 rtl/microwave_timer_pkg.sv | 11 +
 rtl/microwave_timer_bcd_down_digit.sv | 42 ++++
 rtl/microwave_timer.sv | 64 ++++++
 tb/tb_microwave_timer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/microwave_timer_pkg.sv
// Shared constants and types for the microwave M:SS BCD countdown timer.
package microwave_timer_pkg;

    localparam int unsigned DIGIT_W       = 4;
    localparam int unsigned MOD_DECIMAL   = 10;
    localparam int unsigned MOD_SEC_TENS  = 6;
    localparam logic [DIGIT_W-1:0] MAX_BCD = 4'd9;

    typedef logic [DIGIT_W-1:0] bcd_t;

endpackage

// File: rtl/microwave_timer_bcd_down_digit.sv
// One BCD down-counting digit: parallel load, decrement on borrow_in, wraps to MODULUS-1.
module bcd_down_digit
    import microwave_timer_pkg::*;
#(
    parameter int unsigned MODULUS = MOD_DECIMAL
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_value,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] digit,
    output logic               borrow_out
);

    bcd_t digit_next;

    always_comb begin
        digit_next = digit;
        if (load) begin
            digit_next = load_value;
        end else if (borrow_in) begin
            // Out-of-range values above MODULUS-1 still just decrement toward zero.
            if (digit == '0) begin
                digit_next = DIGIT_W'(MODULUS - 1);
            end else begin
                digit_next = digit - DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            digit <= '0;
        end else begin
            digit <= digit_next;
        end
    end

    assign borrow_out = borrow_in && (digit == '0);

endmodule

// File: rtl/microwave_timer.sv
// Three-digit M:SS countdown: keypad shift-load, per-tick decrement, holds at 0:00.
module microwave_timer
    import microwave_timer_pkg::*;
(
    input  logic               clk,
    input  logic               clrn,
    input  logic               loadn,
    input  logic               en,
    input  logic [DIGIT_W-1:0] data,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] mins,
    output logic               zero,
    output logic               tc
);

    logic load_shift;
    logic count;
    logic ones_borrow;
    logic tens_borrow;
    logic mins_borrow;

    // Invalid keypad digits are dropped entirely rather than falling through to count.
    assign load_shift = !loadn && (data <= MAX_BCD);
    assign count      = loadn && en && !zero;

    bcd_down_digit #(.MODULUS(MOD_DECIMAL)) u_sec_ones (
        .clk        (clk),
        .clrn       (clrn),
        .load       (load_shift),
        .load_value (data),
        .borrow_in  (count),
        .digit      (sec_ones),
        .borrow_out (ones_borrow)
    );

    bcd_down_digit #(.MODULUS(MOD_SEC_TENS)) u_sec_tens (
        .clk        (clk),
        .clrn       (clrn),
        .load       (load_shift),
        .load_value (sec_ones),
        .borrow_in  (ones_borrow),
        .digit      (sec_tens),
        .borrow_out (tens_borrow)
    );

    bcd_down_digit #(.MODULUS(MOD_DECIMAL)) u_mins (
        .clk        (clk),
        .clrn       (clrn),
        .load       (load_shift),
        .load_value (sec_tens),
        .borrow_in  (tens_borrow),
        .digit      (mins),
        .borrow_out (mins_borrow)
    );

    assign zero = (mins == '0) && (sec_tens == '0) && (sec_ones == '0);
    assign tc   = en && loadn && (mins == '0) && (sec_tens == '0)
               && (sec_ones == DIGIT_W'(1));

    logic unused_ok;
    assign unused_ok = mins_borrow;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed self-checking bench for microwave_timer with hand-computed expected values.
module tb_microwave_timer;

    logic       clk = 1'b0;
    logic       clrn;
    logic       loadn;
    logic       en;
    logic [3:0] data;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] mins;
    logic       zero;
    logic       tc;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    microwave_timer dut (
        .clk      (clk),
        .clrn     (clrn),
        .loadn    (loadn),
        .en       (en),
        .data     (data),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .mins     (mins),
        .zero     (zero),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] value();
        return {4'h0, mins, sec_tens, sec_ones};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_digit(input logic [3:0] d);
        loadn = 1'b0;
        data  = d;
        step();
        loadn = 1'b1;
    endtask

    initial begin
        clrn  = 1'b0;
        loadn = 1'b1;
        en    = 1'b0;
        data  = 4'd0;
        step();
        check("reset_value", value(), 16'h000);
        check("reset_zero", {15'd0, zero}, 16'd1);
        check("reset_tc", {15'd0, tc}, 16'd0);

        clrn = 1'b1;
        en   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_zero_value", value(), 16'h000);
            check("idle_zero_tc", {15'd0, tc}, 16'd0);
        end

        // Digit entry with en high: load wins.
        en = 1'b1;
        loadn = 1'b0;
        data = 4'd9; step();
        data = 4'd3; step();
        data = 4'd2; step();
        check("entry_932", value(), 16'h932);
        check("entry_zero", {15'd0, zero}, 16'd0);
        data = 4'd12; step();
        check("entry_bad_digit", value(), 16'h932);
        loadn = 1'b1;

        for (int i = 0; i < 3; i++) step();
        check("count_929", value(), 16'h929);

        load_digit(4'd9); load_digit(4'd0); load_digit(4'd0);
        check("load_900", value(), 16'h900);
        step();
        check("borrow_859", value(), 16'h859);

        load_digit(4'd1); load_digit(4'd0); load_digit(4'd0);
        step();
        check("borrow_059", value(), 16'h059);

        load_digit(4'd0); load_digit(4'd7); load_digit(4'd0);
        step();
        check("tens_oob_069", value(), 16'h069);

        load_digit(4'd0); load_digit(4'd0); load_digit(4'd2);
        check("tc_at_002", {15'd0, tc}, 16'd0);
        step();
        check("value_001", value(), 16'h001);
        check("tc_at_001", {15'd0, tc}, 16'd1);
        check("zero_at_001", {15'd0, zero}, 16'd0);
        step();
        check("value_000", value(), 16'h000);
        check("zero_at_000", {15'd0, zero}, 16'd1);
        check("tc_at_000", {15'd0, tc}, 16'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_000", value(), 16'h000);
            check("hold_tc", {15'd0, tc}, 16'd0);
        end

        en = 1'b0;
        load_digit(4'd3); load_digit(4'd4); load_digit(4'd5);
        for (int i = 0; i < 5; i++) step();
        check("en_low_hold", value(), 16'h345);
        en = 1'b1;
        loadn = 1'b0;
        data = 4'd7;
        step();
        check("load_over_count", value(), 16'h457);
        loadn = 1'b1;

        en = 1'b0;
        load_digit(4'd5); load_digit(4'd1); load_digit(4'd7);
        check("pre_reset_517", value(), 16'h517);
        en = 1'b1;
        #2;
        clrn = 1'b0;
        #1;
        check("async_reset_value", value(), 16'h000);
        check("async_reset_zero", {15'd0, zero}, 16'd1);
        step();
        clrn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
